alu_cmd_sequencer: RTL

//  Command front-end and result writeback for the 8-bit combinational ALU.

---
 rtl/alu_cmd_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front-end and result writeback for the 8-bit combinational ALU.
// Accepts one command per cmd valid/ready handshake, reads operands from a
// small register file, drives the ALU inputs from registers, captures the ALU
// result, presents it on a res valid/ready port and writes it back to the
// destination register on the result handshake.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_load                    1 = load immediate, 0 = ALU operation
//   cmd_opcode                  ALU opcode (ignored for loads)
//   cmd_src1/cmd_src2/cmd_dst   register indices
//   cmd_imm                     immediate value for loads
//   alu_opperand_1/2, alu_opcode  registered drive into the ALU
//   alu_result                  combinational ALU output
//   res_valid / res_ready       result handshake
//   res_data, res_dst           captured result and its destination index
//   dbg_addr / dbg_data         combinational register-file debug read
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned REG_AW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_opcode,
  input  logic [REG_AW-1:0] cmd_src1,
  input  logic [REG_AW-1:0] cmd_src2,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_opperand_1,
  output logic [DATA_W-1:0] alu_opperand_2,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_dst,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] OP_ADD = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regfile [NUM_REGS];

  // Handshake flags decoded from state; reset masks acceptance immediately.
  assign cmd_ready = (state == IDLE) && !reset;
  assign res_valid = (state == WB);

  assign dbg_data = regfile[dbg_addr];

  // Sequencer FSM, operand/opcode drive, result capture and writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      alu_opperand_1 <= '0;
      alu_opperand_2 <= '0;
      alu_opcode     <= 3'b000;
      res_data       <= '0;
      res_dst        <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regfile[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // Loads ride through the ALU as imm + 0 so one capture path serves both.
            if (cmd_load) begin
              alu_opperand_1 <= cmd_imm;
              alu_opperand_2 <= '0;
              alu_opcode     <= OP_ADD;
            end else begin
              alu_opperand_1 <= regfile[cmd_src1];
              alu_opperand_2 <= regfile[cmd_src2];
              alu_opcode     <= cmd_opcode;
            end
            res_dst <= cmd_dst;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data <= alu_result;
          state    <= WB;
        end
        WB: begin
          if (res_ready) begin
            regfile[res_dst] <= res_data;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
